// File: rtl/ramdisk_xfer_seq_if.sv
// SRAM-side bus of the RAM-disk block-copy engine.
// The engine is master; the SRAM address/data mux is slave.
interface ramdisk_xfer_seq_if #(
    parameter int AW = 20
);
    logic [7:0]    XD_in;
    logic [AW-1:0] XA;
    logic [7:0]    XD_out;
    logic          XOE;
    logic          nXCS;
    logic          nXWE;

    modport master (
        input  XD_in,
        output XA, XD_out, XOE, nXCS, nXWE
    );

    modport slave (
        output XD_in,
        input  XA, XD_out, XOE, nXCS, nXWE
    );
endinterface

// File: rtl/ramdisk_xfer_seq.sv
// RAM-disk block-copy engine; owns the SRAM only in PHI1 (S2-S3).
// Optional: define XFER_IRQ_EN for the nIRQ completion interrupt.
module ramdisk_xfer_seq #(
    parameter int AW = 20,
    parameter int CW = 16
) (
    input  logic       C7M,
    input  logic       nRES,
    input  logic [2:0] S,
    input  logic       RegWr,
    input  logic [2:0] RegSel,
    input  logic [7:0] RegDin,
    output logic [7:0] RegDout,
    input  logic       Abort,
    ramdisk_xfer_seq_if.master xb,
    output logic       Busy,
    output logic       Done,
    output logic       Aborted
`ifdef XFER_IRQ_EN
    ,
    output logic       nIRQ
`endif
);

    typedef enum logic [2:0] {IDLE, WAIT, RD, WR, ADV} st_e;

    st_e           state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d, xa_q, xa_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    xdo_q, xdo_d, rdo_q, rdo_d;
    logic          pend_q, pend_d, done_q, done_d, abrt_q, abrt_d;
    logic          busy_q, busy_d, xoe_q, xoe_d, ncs_q, ncs_d, nwe_q, nwe_d;
    logic          abort_now;
    logic [23:0]   s24, d24;
`ifdef XFER_IRQ_EN
    logic          irqen_q, irqen_d, nirq_q, nirq_d;
`endif

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        xdo_d     = xdo_q;
        pend_d    = pend_q;
        done_d    = done_q;
        abrt_d    = abrt_q;
        abort_now = Abort | pend_q;
`ifdef XFER_IRQ_EN
        irqen_d   = irqen_q;
`endif
        unique case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (RegWr) begin
                    unique case (RegSel)
                        3'd0: src_d[7:0]     = RegDin;
                        3'd1: src_d[15:8]    = RegDin;
                        3'd2: begin
                            src_d[AW-1:16] = RegDin[AW-17:0];
`ifdef XFER_IRQ_EN
                            irqen_d        = RegDin[7];
`endif
                        end
                        3'd3: dst_d[7:0]     = RegDin;
                        3'd4: dst_d[15:8]    = RegDin;
                        3'd5: dst_d[AW-1:16] = RegDin[AW-17:0];
                        3'd6: cnt_d[7:0]     = RegDin;
                        3'd7: begin
                            cnt_d[CW-1:8] = RegDin[CW-9:0];
                            abrt_d        = 1'b0;
                            // A zero count completes at once, never touching SRAM
                            done_d        = (cnt_d == '0);
                            if (cnt_d != '0) state_d = WAIT;
                        end
                    endcase
                end
            end
            WAIT, RD: begin
                if (abort_now) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    done_d  = 1'b1;
                    abrt_d  = 1'b1;
                end else if (state_q == WAIT) begin
                    if (S == 3'd1) state_d = RD;
                end else if (S == 3'd2) begin
                    xdo_d   = xb.XD_in;
                    state_d = WR;
                end else begin
                    state_d = WAIT;
                end
            end
            WR: begin
                pend_d  = abort_now;
                state_d = ADV;
            end
            ADV: begin
                src_d = src_q + AW'(1);
                dst_d = dst_q + AW'(1);
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1) || abort_now) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    done_d  = 1'b1;
                    abrt_d  = abort_now;
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        xoe_d  = (state_d == RD) || (state_d == WR);
        ncs_d  = !xoe_d;
        nwe_d  = (state_d != WR);
        xa_d   = xa_q;
        if (state_d == RD) xa_d = src_d;
        if (state_d == WR) xa_d = dst_d;
        s24    = 24'(src_d);
        d24    = 24'(dst_d);
        rdo_d  = 8'h00;
        unique case (RegSel)
            3'd0: rdo_d = s24[7:0];
            3'd1: rdo_d = s24[15:8];
            3'd2: rdo_d = s24[23:16];
            3'd3: rdo_d = d24[7:0];
            3'd4: rdo_d = d24[15:8];
            3'd5: rdo_d = d24[23:16];
            3'd6: rdo_d = cnt_d[7:0];
            3'd7: rdo_d = cnt_d[15:8];
        endcase
`ifdef XFER_IRQ_EN
        if (RegSel == 3'd2) rdo_d[7] = irqen_d;
        nirq_d = !(done_d && irqen_d);
`endif
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            xa_q    <= '0;
            xdo_q   <= '0;
            rdo_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
            busy_q  <= 1'b0;
            xoe_q   <= 1'b0;
            ncs_q   <= 1'b1;
            nwe_q   <= 1'b1;
`ifdef XFER_IRQ_EN
            irqen_q <= 1'b0;
            nirq_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            xa_q    <= xa_d;
            xdo_q   <= xdo_d;
            rdo_q   <= rdo_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
            busy_q  <= busy_d;
            xoe_q   <= xoe_d;
            ncs_q   <= ncs_d;
            nwe_q   <= nwe_d;
`ifdef XFER_IRQ_EN
            irqen_q <= irqen_d;
            nirq_q  <= nirq_d;
`endif
        end
    end

    assign RegDout   = rdo_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Aborted   = abrt_q;
    assign xb.XA     = xa_q;
    assign xb.XD_out = xdo_q;
    assign xb.XOE    = xoe_q;
    assign xb.nXCS   = ncs_q;
    assign xb.nXWE   = nwe_q;
`ifdef XFER_IRQ_EN
    assign nIRQ      = nirq_q;
`endif

endmodule

// File: tb/tb_ramdisk_xfer_seq.sv
// Directed bench for ramdisk_xfer_seq; SRAM read data = address[7:0]^5A.
// Defining XFER_IRQ_EN also exercises the nIRQ output.
module tb_ramdisk_xfer_seq;

    logic       C7M = 1'b0;
    logic       nRES = 1'b0;
    logic [2:0] sgen = 3'd1;
    logic       ovr = 1'b0;
    logic [2:0] ovr_v = 3'd0;
    logic [2:0] S;
    logic       RegWr = 1'b0;
    logic [2:0] RegSel = 3'd0;
    logic [7:0] RegDin = 8'd0;
    logic [7:0] RegDout;
    logic       Abort = 1'b0;
    logic       Busy, Done, Aborted;
`ifdef XFER_IRQ_EN
    logic       nIRQ;
`endif

    int checks = 0;
    int errors = 0;
    int ncs = 0;
    int mviol = 0;
    logic [19:0] rda[$];
    logic [19:0] wra[$];
    logic [7:0]  wrd[$];

    ramdisk_xfer_seq_if #(.AW(20)) xb ();

    assign S = ovr ? ovr_v : sgen;
    assign xb.XD_in = xb.XA[7:0] ^ 8'h5A;

    always #5 C7M = ~C7M;

    always @(posedge C7M) sgen <= (sgen == 3'd7) ? 3'd1 : sgen + 3'd1;

    ramdisk_xfer_seq #(.AW(20), .CW(16)) dut (
        .C7M     (C7M),
        .nRES    (nRES),
        .S       (S),
        .RegWr   (RegWr),
        .RegSel  (RegSel),
        .RegDin  (RegDin),
        .RegDout (RegDout),
        .Abort   (Abort),
        .xb      (xb),
        .Busy    (Busy),
        .Done    (Done),
        .Aborted (Aborted)
`ifdef XFER_IRQ_EN
        ,
        .nIRQ    (nIRQ)
`endif
    );

    // Bus monitor: logs SRAM reads/writes and counts phase violations
    always @(negedge C7M) begin
        if (!xb.nXCS) ncs++;
        if (xb.XOE && !xb.nXCS && xb.nXWE) rda.push_back(xb.XA);
        if (!xb.nXWE) begin
            wra.push_back(xb.XA);
            wrd.push_back(xb.XD_out);
        end
        if (xb.XOE && S >= 3'd4) mviol++;
        if (!xb.nXWE && S != 3'd3) mviol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge C7M);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] d);
        @(negedge C7M);
        RegWr = 1'b1; RegSel = sel; RegDin = d;
        @(negedge C7M);
        RegWr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] sel,
                      input logic [7:0] exp);
        @(negedge C7M);
        RegSel = sel;
        @(negedge C7M);
        chk(tag, RegDout, exp);
    endtask

    task automatic setup(input logic [19:0] src, input logic [19:0] dst,
                         input logic [15:0] cnt, input logic ie);
        wr(3'd0, src[7:0]);
        wr(3'd1, src[15:8]);
        wr(3'd2, {ie, 3'b000, src[19:16]});
        wr(3'd3, dst[7:0]);
        wr(3'd4, dst[15:8]);
        wr(3'd5, {4'h0, dst[19:16]});
        wr(3'd6, cnt[7:0]);
        wr(3'd7, cnt[15:8]);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!Done && k < 200) begin
            @(negedge C7M);
            k++;
        end
        chk(tag, Done, 1);
    endtask

    task automatic wait_we(input string tag);
        int k = 0;
        while (xb.nXWE && k < 50) begin
            @(negedge C7M);
            k++;
        end
        chk(tag, xb.nXWE, 0);
    endtask

    initial begin
        int br, bw, c0, k;
        cyc(2);
        chk("rst_xoe", xb.XOE, 0);
        chk("rst_ncs", xb.nXCS, 1);
        chk("rst_nwe", xb.nXWE, 1);
        chk("rst_xa", xb.XA, 0);
        chk("rst_xdo", xb.XD_out, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_abrt", Aborted, 0);
        nRES = 1'b1;
        rd("rst_cnth", 3'd7, 8'h00);

        // Three-byte copy, fully synchronised
        br = rda.size(); bw = wra.size();
        setup(20'h00010, 20'h00100, 16'd3, 1'b1);
        chk("t1_busy", Busy, 1);
        chk("t1_done0", Done, 0);
        wait_done("t1_done");
        chk("t1_busy0", Busy, 0);
        chk("t1_abrt", Aborted, 0);
        chk("t1_nrd", rda.size() - br, 3);
        chk("t1_nwr", wra.size() - bw, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_ra", rda[br+i], 20'h10 + i);
            chk("t1_wa", wra[bw+i], 20'h100 + i);
            chk("t1_wd", wrd[bw+i], (8'h10 + i) ^ 8'h5A);
        end
        rd("t1_srcl", 3'd0, 8'h13);
        rd("t1_dstl", 3'd3, 8'h03);
        rd("t1_dstm", 3'd4, 8'h01);
        rd("t1_cntl", 3'd6, 8'h00);
`ifdef XFER_IRQ_EN
        rd("t1_srch", 3'd2, 8'h80);
        chk("t1_nirq", nIRQ, 0);
        wr(3'd6, 8'h01);
        wr(3'd7, 8'h00);
        chk("t1_nirq_rel", nIRQ, 1);
        wait_done("t1_irq_done");
        chk("t1_nirq2", nIRQ, 0);
        wr(3'd2, 8'h00);
`else
        rd("t1_srch", 3'd2, 8'h00);
`endif

        // Pointer wrap modulo 2^20
        br = rda.size(); bw = wra.size();
        setup(20'hFFFFF, 20'h7FFFF, 16'd2, 1'b0);
        wait_done("t2_done");
        chk("t2_ra0", rda[br], 20'hFFFFF);
        chk("t2_ra1", rda[br+1], 20'h00000);
        chk("t2_wa0", wra[bw], 20'h7FFFF);
        chk("t2_wa1", wra[bw+1], 20'h80000);
        chk("t2_wd1", wrd[bw+1], 8'h5A);
        rd("t2_srch", 3'd2, 8'h00);
        rd("t2_srcl", 3'd0, 8'h01);
        rd("t2_dsth", 3'd5, 8'h08);

        // Zero count: completes with no SRAM access
        wr(3'd6, 8'h00);
        c0 = ncs;
        wr(3'd7, 8'h00);
        chk("t3_done", Done, 1);
        chk("t3_busy", Busy, 0);
        cyc(8);
        chk("t3_busy2", Busy, 0);
        chk("t3_nocs", ncs - c0, 0);

        // Abort in WAIT after one byte
        bw = wra.size();
        setup(20'h00020, 20'h00200, 16'd5, 1'b0);
        wait_we("t4_we");
        cyc(2);
        chk("t4_wait", Busy, 1);
        Abort = 1'b1;
        @(negedge C7M);
        Abort = 1'b0;
        chk("t4_busy", Busy, 0);
        chk("t4_done", Done, 1);
        chk("t4_abrt", Aborted, 1);
        chk("t4_nwr", wra.size() - bw, 1);
        rd("t4_cntl", 3'd6, 8'h04);
        rd("t4_srcl", 3'd0, 8'h21);

        // Abort in WR: the byte completes and counters advance
        bw = wra.size();
        setup(20'h00030, 20'h00300, 16'd3, 1'b0);
        chk("t5_abrt0", Aborted, 0);
        wait_we("t5_we");
        Abort = 1'b1;
        @(negedge C7M);
        Abort = 1'b0;
        chk("t5_adv", Busy, 1);
        @(negedge C7M);
        chk("t5_busy", Busy, 0);
        chk("t5_abrt", Aborted, 1);
        chk("t5_nwr", wra.size() - bw, 1);
        chk("t5_wa", wra[bw], 20'h00300);
        chk("t5_wd", wrd[bw], 8'h30 ^ 8'h5A);
        rd("t5_cntl", 3'd6, 8'h02);
        rd("t5_dstl", 3'd3, 8'h01);

        // Phase slip during RD: byte retried at the same addresses
        br = rda.size(); bw = wra.size();
        setup(20'h00040, 20'h00400, 16'd1, 1'b0);
        k = 0;
        while (!(xb.XOE && xb.nXWE) && k < 50) begin
            @(negedge C7M);
            k++;
        end
        chk("t6_rd", xb.XOE, 1);
        ovr_v = 3'd1;
        ovr = 1'b1;
        @(negedge C7M);
        ovr = 1'b0;
        chk("t6_xoe", xb.XOE, 0);
        chk("t6_nwe", xb.nXWE, 1);
        chk("t6_nowr", wra.size() - bw, 0);
        wait_done("t6_done");
        chk("t6_nrd", rda.size() - br, 2);
        chk("t6_ra1", rda[br+1], 20'h00040);
        chk("t6_nwr", wra.size() - bw, 1);
        chk("t6_wa", wra[bw], 20'h00400);
        chk("t6_wd", wrd[bw], 8'h40 ^ 8'h5A);

        // Reset asserted mid-write
        setup(20'h00050, 20'h00500, 16'd4, 1'b0);
        wait_we("t7_we");
        #2 nRES = 1'b0;
        #1;
        chk("t7_ncs", xb.nXCS, 1);
        chk("t7_nwe", xb.nXWE, 1);
        chk("t7_xoe", xb.XOE, 0);
        chk("t7_busy", Busy, 0);
        @(negedge C7M);
        nRES = 1'b1;
        chk("t7_done", Done, 0);
        rd("t7_srcl", 3'd0, 8'h00);
        rd("t7_dstm", 3'd4, 8'h00);
        rd("t7_cntl", 3'd6, 8'h00);

        chk("phase_guard", mviol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
